// File: rtl/bcd_display_register.sv
// Bus output register: sequential double-dabble BCD conversion feeding a multiplexed,
// active-low common-anode 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_display_register #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  bus,
    input  logic                   signed_mode,
    output logic                   busy,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   negative,
    output logic [6:0]             segments,
    output logic [DIGITS-1:0]      anodes
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_mag;
    logic [BW-1:0]         r_bcd;
    logic [BW-1:0]         w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_sign;
    logic [BW-1:0]         r_bcd_out;
    logic                  r_negative;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_digit;
    logic [3:0]            w_nibble;
    logic                  w_neg_in;

    assign w_neg_in = signed_mode & bus[DATA_WIDTH-1];

    // NOTE: state is updated with <= only; w_next is a pure combinational function of it.
    always_ff @(posedge clk) begin
        if (!clear_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = IDLE;
            SHIFT:   if (r_cnt == CW'(DATA_WIDTH - 1)) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (load) w_next = SHIFT;  // a new load aborts whatever is in flight
    end

    assign busy = (r_state != IDLE);

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_bcd_out  <= '0;
            r_negative <= 1'b0;
        end else if (load) begin
            r_sign <= w_neg_in;
            r_mag  <= w_neg_in ? (~bus + DATA_WIDTH'(1)) : bus;
            r_bcd  <= '0;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
            r_cnt          <= r_cnt + CW'(1);
        end else if (r_state == COMMIT) begin
            r_bcd_out  <= r_bcd;
            r_negative <= r_sign;
        end
    end

    assign bcd_out  = r_bcd_out;
    assign negative = r_negative;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
            r_presc <= '0;
            r_digit <= (r_digit == IW'(DIGITS - 1)) ? '0 : r_digit + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        anodes   = '1;
        w_nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == IW'(i)) begin
                anodes[i] = 1'b0;
                w_nibble  = r_bcd_out[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_bcd_out[4*i +: 4] != 4'd0) w_msd = IW'(i);
        end
    end
`endif

    always_comb begin
        case (w_nibble)
            4'd0:    segments = 7'b1000000;
            4'd1:    segments = 7'b1111001;
            4'd2:    segments = 7'b0100100;
            4'd3:    segments = 7'b0110000;
            4'd4:    segments = 7'b0011001;
            4'd5:    segments = 7'b0010010;
            4'd6:    segments = 7'b0000010;
            4'd7:    segments = 7'b1111000;
            4'd8:    segments = 7'b0000000;
            4'd9:    segments = 7'b0010000;
            default: segments = SEG_BLANK;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (r_digit > w_msd) segments = SEG_BLANK;
`endif
        if (r_negative && r_digit == IW'(DIGITS - 1)) segments = SEG_MINUS;
    end

endmodule

// File: tb/tb_bcd_display_register.sv
// Directed bench for bcd_display_register: reference BCD model feeds a scoreboard queue
// that is drained when each conversion commits; also checks scan order and digit glyphs.
module tb_bcd_display_register;

    localparam int DW = 8;
    localparam int DG = 4;
    localparam int RD = 2;

    localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

    typedef struct {
        logic [4*DG-1:0] bcd;
        logic            neg;
    } exp_t;

    logic            clk = 1'b0;
    logic            clear_n = 1'b0;
    logic            load = 1'b0;
    logic [DW-1:0]   bus = '0;
    logic            signed_mode = 1'b0;
    logic            busy;
    logic [4*DG-1:0] bcd_out;
    logic            negative;
    logic [6:0]      segments;
    logic [DG-1:0]   anodes;

    exp_t sb[$];
    exp_t cur;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    bcd_display_register #(.DATA_WIDTH(DW), .DIGITS(DG), .REFRESH_DIV(RD)) dut (
        .clk(clk), .clear_n(clear_n), .load(load), .bus(bus), .signed_mode(signed_mode),
        .busy(busy), .bcd_out(bcd_out), .negative(negative), .segments(segments),
        .anodes(anodes)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] b, input logic sm);
        exp_t e;
        int   v;
        e.neg = sm && b[DW-1];
        v     = e.neg ? (1 << DW) - int'(b) : int'(b);
        e.bcd = '0;
        for (int i = 0; i < DG; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return e;
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input exp_t e);
        int msd;
        msd = 0;
        for (int i = 1; i < DG; i++) if (e.bcd[4*i +: 4] != 4'd0) msd = i;
        if (idx == DG - 1 && e.neg) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > msd) return 7'b1111111;
`endif
        return GLYPH[int'(e.bcd[4*idx +: 4])];
    endfunction

    task automatic do_load(input logic [DW-1:0] b, input logic sm);
        bus         = b;
        signed_mode = sm;
        load        = 1'b1;
        step();
        load = 1'b0;
        sb.delete();  // any conversion still in flight is aborted
        sb.push_back(model(b, sm));
        check("busy_after_load", 32'(busy), 32'd1);
    endtask

    task automatic wait_commit(input string tag);
        int              n;
        logic            early;
        logic [4*DG-1:0] prev;
        exp_t            e;
        n     = 0;
        early = 1'b0;
        prev  = bcd_out;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
            if (busy === 1'b1 && bcd_out !== prev) early = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(DW + 1));
        check({tag, "_no_early_update"}, 32'(early), 32'd0);
        check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            cur = e;
            check({tag, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
            check({tag, "_neg"}, 32'(negative), 32'(e.neg));
        end
    endtask

    task automatic check_digit(input string tag, input int idx);
        logic [DG-1:0] want;
        int            n;
        want = ~(DG'(1) << idx);
        n    = 0;
        while (anodes !== want && n < 4 * DG * RD) begin
            step();
            n++;
        end
        check({tag, "_anode"}, 32'(anodes), 32'(want));
        check({tag, "_seg"}, 32'(segments), 32'(exp_seg(idx, cur)));
    endtask

    localparam logic [DG-1:0] SCAN [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                           4'b1011, 4'b1011, 4'b0111, 4'b0111};

    initial begin
        int bad;

        // reset with load high and an all-ones bus: nothing may be captured
        clear_n = 1'b0;
        load    = 1'b1;
        bus     = 8'hFF;
        step();
        step();
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_neg", 32'(negative), 32'd0);
        check("rst_anodes", 32'(anodes), 32'b1110);
        check("rst_segments", 32'(segments), 32'b1000000);
        load    = 1'b0;
        clear_n = 1'b1;
        step();
        check("rst_no_load_taken", 32'(busy), 32'd0);

        // refresh scan from a fresh reset
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("scan_%0d", i), 32'(anodes), 32'(SCAN[i % 8]));
            step();
        end

        do_load(8'd255, 1'b0);
        wait_commit("u255");

        do_load(8'h80, 1'b1);
        wait_commit("s_m128");
        check_digit("m128_d3", 3);
        check_digit("m128_d0", 0);
        check_digit("m128_d1", 1);
        check_digit("m128_d2", 2);

        do_load(8'h05, 1'b1);
        wait_commit("s_p5");

        do_load(8'hFF, 1'b1);
        wait_commit("s_m1");
        check_digit("m1_d3", 3);
        check_digit("m1_d2", 2);

        do_load(8'h00, 1'b0);
        wait_commit("zero");
        check_digit("zero_d0", 0);
        check_digit("zero_d1", 1);

        // abort: 99 loaded, then 7 loaded three edges later
        do_load(8'd99, 1'b0);
        step();
        step();
        do_load(8'd7, 1'b0);
        wait_commit("abort_7");
        check_digit("v7_d0", 0);
        check_digit("v7_d1", 1);
        check_digit("v7_d2", 2);
        check_digit("v7_d3", 3);

        // reset lands on the fourth SHIFT edge of a 200 conversion
        do_load(8'd200, 1'b0);
        step();
        step();
        step();
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_neg", 32'(negative), 32'd0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy !== 1'b0 || bcd_out !== '0) bad++;
        end
        check("midrst_no_commit", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
